// File: rtl/softmax_pkg.sv
// Shared definitions for the softmax job scheduler: config register map and FSM states.
package softmax_pkg;

  // Softmax core config register addresses
  localparam int unsigned CFG_RADDR = 32'h00;
  localparam int unsigned CFG_WADDR = 32'h01;
  localparam int unsigned CFG_LEN   = 32'h02;
  localparam int unsigned CFG_GO    = 32'h20;

  typedef enum logic [2:0] {
    S_IDLE,
    S_W_RADDR,
    S_W_WADDR,
    S_W_LEN,
    S_W_GO,
    S_WAIT,
    S_W_CLR
  } sched_state_e;

endpackage

// File: rtl/sched_fifo.sv
// Job queue: DEPTH-entry FIFO with a combinational head and an occupancy count.
module sched_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [W-1:0]           push_data,
  input  logic                   pop,
  output logic [W-1:0]           head,
  output logic [$clog2(DEPTH):0] count
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;
  logic          do_push, do_pop;

  // Next pointers and count; over/underflow requests are dropped
  always_comb begin
    do_push  = push && (count_q != FULL_CNT);
    do_pop   = pop && (count_q != '0);
    wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = do_pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Storage array carries no reset so it can map onto plain RAM
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

  // Pointer and count registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/softmax_job_sched.sv
// Softmax job scheduler: queues job descriptors, programs the core through its
// config bus, waits for completion (or timeout) and reports each finished job.
module softmax_job_sched
  import softmax_pkg::*;
#(
  parameter int AW      = 12,
  parameter int DW      = 32,
  parameter int CW      = 6,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 1 << 20
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   job_valid,
  output logic                   job_ready,
  input  logic [DW-1:0]          job_raddr,
  input  logic [DW-1:0]          job_waddr,
  input  logic [AW-1:0]          job_iolen,
  output logic                   config_ena,
  output logic [CW-1:0]          config_addr,
  output logic [DW-1:0]          config_wdata,
  input  logic                   softmax_core_done,
  output logic                   done_valid,
  output logic                   done_timeout,
  output logic [31:0]            done_cycles,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] q_count
);
  localparam int EW = 2*DW + AW;
  localparam int QW = $clog2(DEPTH) + 1;

  sched_state_e state_q, state_d;
  logic [EW-1:0] job_q, job_d;
  logic [31:0]   cyc_q, cyc_d;
  logic          to_q, to_d;
  logic [EW-1:0] fifo_head;
  logic          pop;

  logic [DW-1:0] cur_raddr, cur_waddr;
  logic [AW-1:0] cur_iolen;

  assign cur_raddr = job_q[EW-1 -: DW];
  assign cur_waddr = job_q[AW+DW-1 -: DW];
  assign cur_iolen = job_q[AW-1:0];

  // Ready comes from the registered count only, so a push can never land on a full queue
  assign job_ready = (q_count < QW'(DEPTH));

  sched_fifo #(
    .W     (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (job_valid && job_ready),
    .push_data ({job_raddr, job_waddr, job_iolen}),
    .pop       (pop),
    .head      (fifo_head),
    .count     (q_count)
  );

  // Next-state, config bus and completion outputs
  always_comb begin
    state_d      = state_q;
    job_d        = job_q;
    cyc_d        = cyc_q;
    to_d         = to_q;
    pop          = 1'b0;
    config_ena   = 1'b0;
    config_addr  = '0;
    config_wdata = '0;
    done_valid   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (q_count != '0) begin
          pop     = 1'b1;
          job_d   = fifo_head;
          state_d = S_W_RADDR;
        end
      end
      S_W_RADDR: begin
        config_ena   = 1'b1;
        config_addr  = CW'(CFG_RADDR);
        config_wdata = cur_raddr;
        state_d      = S_W_WADDR;
      end
      S_W_WADDR: begin
        config_ena   = 1'b1;
        config_addr  = CW'(CFG_WADDR);
        config_wdata = cur_waddr;
        state_d      = S_W_LEN;
      end
      S_W_LEN: begin
        config_ena   = 1'b1;
        config_addr  = CW'(CFG_LEN);
        config_wdata = DW'(cur_iolen);
        state_d      = S_W_GO;
      end
      S_W_GO: begin
        config_ena   = 1'b1;
        config_addr  = CW'(CFG_GO);
        config_wdata = DW'(1);
        cyc_d        = '0;
        to_d         = 1'b0;
        state_d      = S_WAIT;
      end
      S_WAIT: begin
        if (cyc_q != '1) cyc_d = cyc_q + 32'd1;
        if (softmax_core_done) begin
          to_d    = 1'b0;
          state_d = S_W_CLR;
        end else if (cyc_q == 32'(TIMEOUT - 1)) begin
          to_d    = 1'b1;
          state_d = S_W_CLR;
        end
      end
      S_W_CLR: begin
        // Dropping GO here guarantees the next job's GO is a fresh rising edge
        config_ena   = 1'b1;
        config_addr  = CW'(CFG_GO);
        config_wdata = '0;
        done_valid   = 1'b1;
        if (q_count != '0) begin
          pop     = 1'b1;
          job_d   = fifo_head;
          state_d = S_W_RADDR;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, working job and counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      job_q   <= '0;
      cyc_q   <= '0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      job_q   <= job_d;
      cyc_q   <= cyc_d;
      to_q    <= to_d;
    end
  end

  assign done_timeout = done_valid & to_q;
  assign done_cycles  = cyc_q;
  assign busy         = (state_q != S_IDLE);

endmodule
